// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU port, loader port and RAM side of mem_port_arbiter.
// slave is the arbiter's view; master is the requesters/RAM view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;

    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic [DATA_WIDTH-1:0] ld_rdata;
    logic                  ld_ack;
    logic                  ld_lock;

    logic                  busy;
    logic                  mem_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_rdata, ld_ack,
        output busy, mem_enable, mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_rdata, ld_ack,
        input  busy, mem_enable, mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM between the CPU and the loader: IDLE/ACCESS/RESP grant FSM
// with round-robin tie-break, loader lock and per-requester held read data.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic               Clock,
    input  logic               clear,
    mem_port_arbiter_if.slave  io_bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Grant owner encoding: 0 = CPU, 1 = loader.
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ld_rdata;

    logic w_cpu_elig;
    logic w_ld_elig;
    logic w_grant;
    logic w_grant_ld;
    logic w_access;
    logic w_resp;

    assign w_cpu_elig = io_bus.cpu_req & ~io_bus.ld_lock;
    assign w_ld_elig  = io_bus.ld_req;

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_grant_ld = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cpu_elig || w_ld_elig) begin
                    w_grant    = 1'b1;
                    // On a tie the requester not granted last time wins.
                    w_grant_ld = w_ld_elig & (~w_cpu_elig | (r_last_grant == GNT_CPU));
                    w_next     = ACCESS;
                end
            end
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state      <= IDLE;
            r_owner      <= GNT_CPU;
            r_last_grant <= GNT_LD;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_ld_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner      <= w_grant_ld;
                r_last_grant <= w_grant_ld;
                r_we         <= w_grant_ld ? io_bus.ld_we    : io_bus.cpu_we;
                r_addr       <= w_grant_ld ? io_bus.ld_addr  : io_bus.cpu_addr;
                r_wdata      <= w_grant_ld ? io_bus.ld_wdata : io_bus.cpu_wdata;
            end
            if (r_state == ACCESS && !r_we) begin
                if (r_owner == GNT_LD) r_ld_rdata  <= io_bus.mem_rdata;
                else                   r_cpu_rdata <= io_bus.mem_rdata;
            end
        end
    end

    assign w_access = (r_state == ACCESS);
    assign w_resp   = (r_state == RESP);

    assign io_bus.busy       = w_access | w_resp;
    assign io_bus.mem_enable = w_access;
    assign io_bus.mem_read   = w_access & ~r_we;
    assign io_bus.mem_write  = w_access & r_we;
    assign io_bus.mem_addr   = w_access ? r_addr  : '0;
    assign io_bus.mem_wdata  = w_access ? r_wdata : '0;
    assign io_bus.cpu_ack    = w_resp & (r_owner == GNT_CPU);
    assign io_bus.ld_ack     = w_resp & (r_owner == GNT_LD);
    assign io_bus.cpu_rdata  = r_cpu_rdata;
    assign io_bus.ld_rdata   = r_ld_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 512x32 RAM.
module tb_mem_port_arbiter;
    logic Clock = 1'b0;
    logic clear;
    always #5 Clock = ~Clock;

    mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .Clock  (Clock),
        .clear  (clear),
        .io_bus (bus)
    );

    logic [31:0] ram [0:511];

    assign bus.mem_rdata = (bus.mem_enable && bus.mem_read) ? ram[bus.mem_addr] : 32'h0;
    always @(posedge Clock)
        if (bus.mem_enable && bus.mem_write) ram[bus.mem_addr] = bus.mem_wdata;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Bounded wait for the selected ack; returns edges elapsed (20 on timeout).
    task automatic wait_ack(input bit use_ld, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(use_ld ? bus.ld_ack : bus.cpu_ack) && cyc < 20);
    endtask

    int cyc;
    int seen;
    int ack_n;
    int ack_cyc [4];
    bit ack_ld  [4];

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[9'h010] = 32'hDEADBEEF;
        ram[9'h020] = 32'hA5A5A5A5;

        clear = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
        bus.ld_lock = 1'b0;
        tick();
        tick();
        clear = 1'b0;

        // Reset state
        chk("rst_busy",      bus.busy,       32'd0);
        chk("rst_mem_en",    bus.mem_enable, 32'd0);
        chk("rst_mem_rw",    {bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_mem_addr",  bus.mem_addr,   32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,  32'd0);
        chk("rst_acks",      {bus.cpu_ack, bus.ld_ack}, 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata,  32'd0);
        chk("rst_ld_rdata",  bus.ld_rdata,   32'd0);

        // CPU read of 0x010 with exact latency
        bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010; bus.cpu_req = 1'b1;
        tick();
        chk("rd_mem_read",   bus.mem_read,   32'd1);
        chk("rd_mem_en",     bus.mem_enable, 32'd1);
        chk("rd_mem_addr",   bus.mem_addr,   32'h010);
        chk("rd_busy_acc",   bus.busy,       32'd1);
        chk("rd_ack_early",  bus.cpu_ack,    32'd0);
        tick();
        chk("rd_cpu_ack",    bus.cpu_ack,    32'd1);
        chk("rd_cpu_rdata",  bus.cpu_rdata,  32'hDEADBEEF);
        chk("rd_ld_ack",     bus.ld_ack,     32'd0);
        chk("rd_resp_strb",  bus.mem_enable, 32'd0);
        bus.cpu_req = 1'b0;
        tick();
        chk("rd_ack_pulse",  bus.cpu_ack,    32'd0);
        chk("rd_busy_idle",  bus.busy,       32'd0);
        tick();
        chk("rd_rdata_held", bus.cpu_rdata,  32'hDEADBEEF);

        // Loader write to top address, then CPU read back
        bus.ld_we = 1'b1; bus.ld_addr = 9'h1FF; bus.ld_wdata = 32'h12345678; bus.ld_req = 1'b1;
        wait_ack(1'b1, cyc);
        bus.ld_req = 1'b0;
        chk("ldw_latency",   cyc,            32'd2);
        chk("ldw_cpu_ack",   bus.cpu_ack,    32'd0);
        tick();
        chk("ldw_ram",       ram[9'h1FF],    32'h12345678);
        bus.cpu_we = 1'b0; bus.cpu_addr = 9'h1FF; bus.cpu_req = 1'b1;
        wait_ack(1'b0, cyc);
        bus.cpu_req = 1'b0;
        chk("rb_latency",    cyc,            32'd2);
        chk("rb_cpu_rdata",  bus.cpu_rdata,  32'h12345678);
        chk("rb_ld_rdata",   bus.ld_rdata,   32'd0);
        tick();

        // Contention after reset: CPU wins first tie, then alternation
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
        bus.ld_we  = 1'b0; bus.ld_addr  = 9'h1FF;
        bus.cpu_req = 1'b1; bus.ld_req = 1'b1;
        ack_n = 0;
        for (int i = 0; i < 4; i++) begin ack_cyc[i] = -1; ack_ld[i] = 1'b0; end
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.cpu_ack && ack_n < 4) begin ack_cyc[ack_n] = c; ack_ld[ack_n] = 1'b0; ack_n++; end
            if (bus.ld_ack && ack_n < 4)  begin ack_cyc[ack_n] = c; ack_ld[ack_n] = 1'b1; ack_n++; end
            bus.cpu_req = !bus.cpu_ack;
            bus.ld_req  = !bus.ld_ack;
        end
        bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
        chk("cont_count", ack_n, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_owner%0d", i), {31'd0, ack_ld[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("cont_cycle%0d", i), ack_cyc[i], 2 + 3 * i);
        end
        chk("cont_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        chk("cont_ld_rdata",  bus.ld_rdata,  32'h12345678);
        tick();

        // Loader lock blocks CPU grants
        bus.ld_lock = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 9'h020; bus.cpu_req = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.cpu_ack || bus.mem_enable || bus.busy) seen++;
        end
        chk("lock_no_activity", seen, 32'd0);
        bus.ld_lock = 1'b0;
        wait_ack(1'b0, cyc);
        bus.cpu_req = 1'b0;
        chk("unlock_latency",  cyc,           32'd2);
        chk("unlock_rdata",    bus.cpu_rdata, 32'hA5A5A5A5);
        tick();

        // Clear during ACCESS of a CPU read
        bus.cpu_addr = 9'h010; bus.cpu_req = 1'b1;
        tick();
        chk("mid_in_access", bus.mem_enable, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0; bus.cpu_req = 1'b0;
        chk("mid_busy",      bus.busy,       32'd0);
        chk("mid_ack",       bus.cpu_ack,    32'd0);
        chk("mid_rdata",     bus.cpu_rdata,  32'd0);
        chk("mid_strobe",    bus.mem_enable, 32'd0);
        tick();
        chk("mid_ack_after", bus.cpu_ack,    32'd0);
        chk("mid_idle",      bus.busy,       32'd0);

        // Write does not disturb held read data
        bus.cpu_we = 1'b0; bus.cpu_addr = 9'h020; bus.cpu_req = 1'b1;
        wait_ack(1'b0, cyc);
        bus.cpu_req = 1'b0;
        chk("wi_read",       bus.cpu_rdata,  32'hA5A5A5A5);
        tick();
        bus.cpu_we = 1'b1; bus.cpu_wdata = 32'h0; bus.cpu_req = 1'b1;
        wait_ack(1'b0, cyc);
        bus.cpu_req = 1'b0;
        chk("wi_latency",    cyc,            32'd2);
        chk("wi_cpu_rdata",  bus.cpu_rdata,  32'hA5A5A5A5);
        chk("wi_ld_rdata",   bus.ld_rdata,   32'd0);
        chk("wi_ram",        ram[9'h020],    32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single RAM512x32 memory between the CPU datapath/control sequencer and a program/data loader port. It sits between the requesters and the RAM in the System top level and replaces the direct MAR/MDR-to-RAM wiring and the separate override path. It grants one access at a time through a three-state FSM, with round-robin tie-breaking and a loader lock. Read data is held per requester.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 9, memory address width (512 words)

Clocking and reset (already decided): one clock; reset is synchronous and active-high.

- Clock  in  1  single system clock, rising edge
- clear  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; hold high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address (MAR)
- cpu_wdata  in  DATA_WIDTH  CPU write data (MDR)
- cpu_rdata  out  DATA_WIDTH  last CPU read data, held
- cpu_ack  out  1  one-cycle completion pulse
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_ack  same widths and meanings as the cpu_* ports, loader side
- ld_lock  in  1  loader owns memory exclusively; CPU requests are not granted
- busy  out  1  high in ACCESS and RESP
- mem_enable, mem_read, mem_write  out  1  RAM strobes
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, combinational while enable&read

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: eligible requesters are ld_req, and cpu_req when ld_lock=0.
  - If no requester is eligible, stay in IDLE.
  - Otherwise register the winner's we/addr/wdata and the grant owner, then go to ACCESS.
- Arbitration: with a single eligible requester, that requester wins. With both eligible, the winner is the requester not recorded in last_grant. last_grant updates on every grant and resets to LOADER, so the CPU wins the first tie.
- ACCESS: mem_enable=1, mem_addr and mem_wdata come from the registered values, and mem_read=~we, mem_write=we. On a read, mem_rdata is captured into the owner's rdata register at the end of the cycle. Next state is RESP.
- RESP: all RAM strobes are 0 and the owner's ack=1 for exactly this cycle. Next state is IDLE.
- The non-owner's rdata and ack are unchanged. rdata registers hold until that requester's next read; writes do not alter them.
- ld_lock asserted while a CPU access is in ACCESS or RESP does not abort it. The lock only affects the next grant.
- Requesters must keep req and fields stable until ack and must drop req on the edge that samples ack. A req still high in the IDLE cycle after RESP is treated as a new request.
- Addresses are used as given: no wrap or range check, ADDR_WIDTH bits only.

## Timing
- Reset values: cpu_rdata=0, ld_rdata=0, cpu_ack=0, ld_ack=0, busy=0, mem_enable=mem_read=mem_write=0, mem_addr=0, mem_wdata=0, state=IDLE, last_grant=LOADER.
- clear during ACCESS or RESP:
  - the next cycle is IDLE with all strobes 0;
  - the in-flight access gets no ack and no rdata update;
  - a write already strobed in ACCESS may have reached the RAM.
- Latency: req is high in the IDLE cycle at edge k; ACCESS runs in cycle k+1; ack and valid rdata appear in cycle k+2.
- Throughput: one access per 3 cycles; minimum request-to-request spacing is 3 cycles.
- Outputs are registered or decoded from state only, with no combinational path from req to mem_*.
- A loser keeps waiting and is granted in the IDLE following the winner's RESP, because of round-robin.

## Test plan
- CPU read: preload RAM[0x010]=0xDEADBEEF; cpu_req with cpu_we=0, cpu_addr=0x010 -> mem_read high one cycle later, cpu_ack two cycles later, cpu_rdata=0xDEADBEEF held afterwards; ld_ack stays 0.
- Loader write then CPU read back: ld write 0x12345678 to 0x1FF -> ld_ack after 2 cycles; then a CPU read of 0x1FF -> cpu_rdata=0x12345678.
- Contention: cpu_req and ld_req asserted together and held repeatedly -> grant order CPU, LD, CPU, LD; acks 3 cycles apart.
- Lock: ld_lock=1 with cpu_req held for 10 cycles -> no cpu_ack and no RAM strobe. Drop ld_lock -> cpu_ack 2 cycles later.
- Reset mid-access: clear in the ACCESS cycle of a CPU read -> no cpu_ack, cpu_rdata=0, busy=0 next cycle, FSM returns to IDLE.
- Write isolation: CPU read of 0x020 (value 0xA5A5A5A5), then CPU write of 0x0 to 0x020 -> cpu_rdata remains 0xA5A5A5A5; ld_rdata remains 0.
